// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the arbitrated shared-bus interconnect.
//   bus_state_e : transaction FSM states (IDLE / XFER / RESP)
//   ERR_OK/ERR_FAULT : values driven on m_err alongside m_ack
//   idx_w()     : index width for an N-entry vector, never narrower than 1 bit
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    localparam logic ERR_OK    = 1'b0;
    localparam logic ERR_FAULT = 1'b1;   // decode miss or slave timeout

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_interconnect_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at index ptr and wraps,
// so the requester at ptr has highest priority this round.
//   req   : request vector, one bit per requester
//   ptr   : first index to consider
//   grant : one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int N     = 2,
    localparam int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W:0]   pos;     // one extra bit so ptr+i can exceed N before wrapping
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (pos >= (PTR_W + 1)'(N))
                pos = pos - (PTR_W + 1)'(N);
            idx = pos[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// -----------------------------------------------------------------------------
// bus_interconnect
// N_MASTER requesters share one arbitrated channel to N_SLAVE peripherals.
// One transaction is outstanding at a time: IDLE arbitrates and decodes,
// XFER holds the slave select until ack or timeout, RESP pulses m_ack.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   m_req/m_we      : per-master request level and write flag
//   m_addr/m_wdata/m_be : per-master packed command fields
//   m_ack           : one-hot one-cycle completion to the winning master
//   m_err/m_rdata   : response status and read data, valid with m_ack
//   s_req           : one-hot slave select, held for the transfer
//   s_we/s_addr/s_wdata/s_be : registered command shared by all slaves
//   s_rdata/s_ack   : per-slave read data and completion pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                              N_MASTER   = 2,
    parameter int                              N_SLAVE    = 4,
    parameter int                              ADDR_W     = 32,
    parameter int                              DATA_W     = 32,
    parameter logic [N_SLAVE-1:0][ADDR_W-1:0]  SLAVE_BASE = '0,
    parameter logic [N_SLAVE-1:0][ADDR_W-1:0]  SLAVE_MASK = '0,
    parameter int                              TIMEOUT    = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MASTER-1:0]                 m_req,
    input  logic [N_MASTER-1:0]                 m_we,
    input  logic [N_MASTER-1:0][ADDR_W-1:0]     m_addr,
    input  logic [N_MASTER-1:0][DATA_W-1:0]     m_wdata,
    input  logic [N_MASTER-1:0][DATA_W/8-1:0]   m_be,
    output logic [N_MASTER-1:0]                 m_ack,
    output logic                                m_err,
    output logic [DATA_W-1:0]                   m_rdata,
    output logic [N_SLAVE-1:0]                  s_req,
    output logic                                s_we,
    output logic [ADDR_W-1:0]                   s_addr,
    output logic [DATA_W-1:0]                   s_wdata,
    output logic [DATA_W/8-1:0]                 s_be,
    input  logic [N_SLAVE-1:0][DATA_W-1:0]      s_rdata,
    input  logic [N_SLAVE-1:0]                  s_ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int MW    = idx_w(N_MASTER);
    localparam int SW    = idx_w(N_SLAVE);
    localparam int CNT_W = idx_w(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]    TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [N_MASTER-1:0] M_ONE  = N_MASTER'(1);
    localparam logic [N_SLAVE-1:0]  S_ONE  = N_SLAVE'(1);

    bus_state_e       state;
    logic [MW-1:0]    ptr;
    logic [MW-1:0]    winner;
    logic [SW-1:0]    sel;
    logic [CNT_W-1:0] cnt;
    logic             miss_pend;

    // ---------------- arbitration and command mux ----------------
    logic [N_MASTER-1:0] gnt;
    logic [MW-1:0]       gnt_idx;
    logic                mux_we;
    logic [ADDR_W-1:0]   mux_addr;
    logic [DATA_W-1:0]   mux_wdata;
    logic [BE_W-1:0]     mux_be;

    rr_arbiter #(.N(N_MASTER)) u_arb (
        .req   (m_req),
        .ptr   (ptr),
        .grant (gnt)
    );

    // gnt is one-hot, so an AND-OR mux selects the winner's command
    always_comb begin
        gnt_idx   = '0;
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        mux_be    = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (gnt[i]) begin
                gnt_idx   = MW'(i);
                mux_we    = m_we[i];
                mux_addr  = m_addr[i];
                mux_wdata = m_wdata[i];
                mux_be    = m_be[i];
            end
        end
    end

    // ---------------- address decode ----------------
    logic [N_SLAVE-1:0] hit;
    logic [SW-1:0]      hit_idx;
    logic               any_hit;

    for (genvar i = 0; i < N_SLAVE; i++) begin : g_dec
        assign hit[i] = (mux_addr & SLAVE_MASK[i]) == SLAVE_BASE[i];
    end

    // overlapping windows resolve to the lowest index
    always_comb begin
        hit_idx = '0;
        any_hit = |hit;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (hit[i])
                hit_idx = SW'(i);
        end
    end

    // ---------------- transaction FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            sel       <= '0;
            cnt       <= '0;
            miss_pend <= 1'b0;
            m_ack     <= '0;
            m_err     <= 1'b0;
            m_rdata   <= '0;
            s_req     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_be      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m_ack <= '0;
                    if (|m_req) begin
                        winner  <= gnt_idx;
                        s_we    <= mux_we;
                        s_addr  <= mux_addr;
                        s_wdata <= mux_wdata;
                        s_be    <= mux_be;
                        if (any_hit) begin
                            s_req <= S_ONE << hit_idx;
                            sel   <= hit_idx;
                            cnt   <= '0;
                            state <= XFER;
                        end else begin
                            // A miss spends one cycle in RESP before acking so
                            // its ack lands where the fastest slave's would.
                            miss_pend <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                XFER: begin
                    // ack wins over a timeout in the same cycle
                    if (s_ack[sel]) begin
                        s_req   <= '0;
                        m_err   <= ERR_OK;
                        m_rdata <= s_we ? '0 : s_rdata[sel];
                        m_ack   <= M_ONE << winner;
                        state   <= RESP;
                    end else if (TIMEOUT != 0 && cnt == TO_VAL) begin
                        s_req   <= '0;
                        m_err   <= ERR_FAULT;
                        m_rdata <= '0;
                        m_ack   <= M_ONE << winner;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (miss_pend) begin
                        miss_pend <= 1'b0;
                        m_err     <= ERR_FAULT;
                        m_rdata   <= '0;
                        m_ack     <= M_ONE << winner;
                    end else begin
                        m_ack <= '0;
                        ptr   <= (winner == MW'(N_MASTER - 1)) ? '0 : winner + 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench: two masters, four slaves on 256 MiB windows
// (slave i at 0xi000_0000, mask 0xF000_0000), timeout of 4 cycles.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_interconnect;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam logic [NS-1:0][31:0] BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS-1:0][31:0] MASK = {NS{32'hF000_0000}};

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NM-1:0]          m_req, m_we;
    logic [NM-1:0][31:0]    m_addr, m_wdata;
    logic [NM-1:0][3:0]     m_be;
    logic [NM-1:0]          m_ack;
    logic                   m_err;
    logic [31:0]            m_rdata;
    logic [NS-1:0]          s_req;
    logic                   s_we;
    logic [31:0]            s_addr, s_wdata;
    logic [3:0]             s_be;
    logic [NS-1:0][31:0]    s_rdata;
    logic [NS-1:0]          s_ack;

    int n_checks = 0;
    int n_fail   = 0;

    bus_interconnect #(
        .N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(32), .DATA_W(32),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h sreq=%b we=%b addr=%h wdata=%h be=%b, want all 0",
                     m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_be);
        end
        rst = 1'b0;
        tick();
    endtask

    // M0 reads slave 1; slave acks two cycles after s_req rises
    task automatic test_single_read();
        m_req = 2'b01; m_we = 2'b00; m_addr[0] = 32'h1000_0004;
        tick();                                       // t+1
        n_checks++;
        if (s_req !== 4'b0010 || s_addr !== 32'h1000_0004 || s_we !== 1'b0) begin
            n_fail++;
            $display("FAIL read_cmd: got sreq=%b addr=%h we=%b, want 0010 10000004 0", s_req, s_addr, s_we);
        end
        tick();                                       // t+2
        n_checks++;
        if (m_ack !== 2'b00 || s_req !== 4'b0010) begin
            n_fail++;
            $display("FAIL read_hold: got ack=%b sreq=%b, want 00 0010", m_ack, s_req);
        end
        tick();                                       // t+3: slave acks
        s_rdata[1] = 32'hCAFE_BABE; s_ack = 4'b0010;
        tick();                                       // t+4
        s_ack = '0;
        n_checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_BABE || s_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL read_resp: got ack=%b err=%b rdata=%h sreq=%b, want 01 0 cafebabe 0000",
                     m_ack, m_err, m_rdata, s_req);
        end
        m_req = 2'b00;
        tick();
        n_checks++;
        if (m_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL read_ack_pulse: got ack=%b, want 00", m_ack);
        end
    endtask

    task automatic test_decode_miss();
        m_req = 2'b10; m_we = 2'b00; m_addr[1] = 32'hF000_0000;
        tick();                                       // t+1
        n_checks++;
        if (s_req !== 4'b0000 || m_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_t1: got sreq=%b ack=%b, want 0000 00", s_req, m_ack);
        end
        tick();                                       // t+2
        n_checks++;
        if (m_ack !== 2'b10 || m_err !== 1'b1 || m_rdata !== 32'h0 || s_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL miss_resp: got ack=%b err=%b rdata=%h sreq=%b, want 10 1 00000000 0000",
                     m_ack, m_err, m_rdata, s_req);
        end
        m_req = 2'b00;
        tick();
        n_checks++;
        if (m_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_ack_pulse: got ack=%b, want 00", m_ack);
        end
    endtask

    // Both masters request continuously; grants alternate starting at M0
    task automatic test_contention();
        logic [1:0]  exp_ack;
        logic [3:0]  exp_sel;
        logic [31:0] exp_data;
        int          waited;
        m_req = 2'b11; m_we = 2'b00;
        m_addr[0] = 32'h1000_0100; m_addr[1] = 32'h3000_0200;
        s_rdata[1] = 32'h1111_0001; s_rdata[3] = 32'h3333_0003;
        for (int n = 0; n < 4; n++) begin
            exp_ack  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_sel  = (n % 2 == 0) ? 4'b0010 : 4'b1000;
            exp_data = (n % 2 == 0) ? 32'h1111_0001 : 32'h3333_0003;
            tick();
            waited = 1;
            while (s_req == '0 && waited < 8) begin
                tick();
                waited++;
            end
            n_checks++;
            if (s_req !== exp_sel || waited != ((n == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got sreq=%b after %0d cycles, want %b after %0d",
                         n, s_req, waited, exp_sel, (n == 0) ? 1 : 2);
            end
            s_ack = s_req;
            tick();
            s_ack = '0;
            n_checks++;
            if (m_ack !== exp_ack || m_rdata !== exp_data || m_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_ack%0d: got ack=%b rdata=%h err=%b, want %b %h 0",
                         n, m_ack, m_rdata, m_err, exp_ack, exp_data);
            end
            if (n == 3) m_req = 2'b00;
        end
        tick();
        n_checks++;
        if (m_ack !== 2'b00 || s_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_quiet: got ack=%b sreq=%b, want 00 0000", m_ack, s_req);
        end
    endtask

    // Slave 2 never acks; a stray ack from slave 1 and a late ack are ignored
    task automatic test_timeout();
        m_req = 2'b01; m_we = 2'b00; m_addr[0] = 32'h2000_0000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            s_ack = (c == 2) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (s_req !== 4'b0100 || m_ack !== 2'b00) begin
                n_fail++;
                $display("FAIL timeout_hold%0d: got sreq=%b ack=%b, want 0100 00", c, s_req, m_ack);
            end
        end
        tick();
        n_checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b1 || m_rdata !== 32'h0 || s_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h sreq=%b, want 01 1 00000000 0000",
                     m_ack, m_err, m_rdata, s_req);
        end
        m_req = 2'b00;
        tick(); tick();
        s_rdata[2] = 32'hBAD0_BAD0; s_ack = 4'b0100;  // late ack
        for (int c = 0; c < 3; c++) begin
            tick();
            s_ack = '0;
            n_checks++;
            if (m_ack !== 2'b00 || s_req !== 4'b0000) begin
                n_fail++;
                $display("FAIL late_ack%0d: got ack=%b sreq=%b, want 00 0000", c, m_ack, s_req);
            end
        end
    endtask

    task automatic test_write_be();
        m_req = 2'b01; m_we = 2'b01; m_addr[0] = 32'h0000_0010;
        m_wdata[0] = 32'h1234_5678; m_be[0] = 4'b0011;
        tick();
        n_checks++;
        if (s_req !== 4'b0001 || s_we !== 1'b1 || s_wdata !== 32'h1234_5678 || s_be !== 4'b0011) begin
            n_fail++;
            $display("FAIL write_cmd: got sreq=%b we=%b wdata=%h be=%b, want 0001 1 12345678 0011",
                     s_req, s_we, s_wdata, s_be);
        end
        s_rdata[0] = 32'hDEAD_BEEF; s_ack = 4'b0001;  // ack in first XFER cycle
        tick();
        s_ack = '0;
        n_checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b0 || m_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL write_resp: got ack=%b err=%b rdata=%h, want 01 0 00000000", m_ack, m_err, m_rdata);
        end
        m_req = 2'b00; m_we = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        m_req = 2'b01; m_addr[0] = 32'h2000_0040;
        tick();
        n_checks++;
        if (s_req !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_pre: got sreq=%b, want 0100", s_req);
        end
        tick();
        rst = 1'b1; m_req = 2'b00;
        #1;
        n_checks++;
        if ({m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_be} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got ack=%b err=%b rdata=%h sreq=%b we=%b addr=%h wdata=%h be=%b, want all 0",
                     m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_be);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (m_ack !== 2'b00 || s_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_no_ack: got ack=%b sreq=%b, want 00 0000", m_ack, s_req);
        end
        m_req = 2'b10; m_addr[1] = 32'h3000_0004;
        tick();
        n_checks++;
        if (s_req !== 4'b1000 || s_addr !== 32'h3000_0004) begin
            n_fail++;
            $display("FAIL rst_regrant: got sreq=%b addr=%h, want 1000 30000004", s_req, s_addr);
        end
        s_rdata[3] = 32'h55AA_55AA; s_ack = 4'b1000;
        tick();
        s_ack = '0;
        n_checks++;
        if (m_ack !== 2'b10 || m_err !== 1'b0 || m_rdata !== 32'h55AA_55AA) begin
            n_fail++;
            $display("FAIL rst_resp: got ack=%b err=%b rdata=%h, want 10 0 55aa55aa", m_ack, m_err, m_rdata);
        end
        m_req = 2'b00;
        tick();
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        s_rdata = '0; s_ack = '0;
        test_reset();
        test_single_read();
        test_decode_miss();
        test_contention();
        test_timeout();
        test_write_be();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
